// File: rtl/sequential_divider.sv
// Restoring sequential divider: 2*data_width dividend / data_width divisor,
// signed or unsigned, one quotient bit per cycle, start/done handshake.
// Build option: define DIVIDER_SAT_EN to saturate the quotient on overflow;
// without it an overflowing quotient is the low bits of the full quotient.
module sequential_divider #(
  parameter int data_width = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      is_signed,
  input  logic [2*data_width-1:0]   dividend,
  input  logic [data_width-1:0]     divisor,
  output logic                      busy,
  output logic                      done,
  output logic [data_width-1:0]     quotient,
  output logic [data_width-1:0]     remainder,
  output logic                      overflow,
  output logic                      div_by_zero
);

  localparam int W  = data_width;
  localparam int DW = 2 * data_width;
  localparam int CW = $clog2(DW + 1);
  localparam logic [DW-1:0] HALF_RANGE = DW'(1) << (W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t          state_q;
  logic [W:0]      rem_q;
  logic [DW-1:0]   dvd_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    dsr_mag_q;
  logic [W-1:0]    dvd_low_q;
  logic            sgn_q;
  logic            dvd_neg_q;
  logic            dsr_neg_q;
  logic            zero_q;
  logic            busy_q;
  logic            done_q;
  logic [W-1:0]    quotient_q;
  logic [W-1:0]    remainder_q;
  logic            overflow_q;
  logic            dbz_q;

  logic            dvd_neg_d;
  logic            dsr_neg_d;
  logic [DW-1:0]   dvd_mag_d;
  logic [W-1:0]    dsr_mag_d;
  logic [W+1:0]    shift_rem_d;
  logic [W+1:0]    dsr_ext_d;
  logic            keep_d;
  logic [W:0]      rem_next_d;
  logic [DW-1:0]   dvd_next_d;
  logic            q_neg_d;
  logic [DW-1:0]   q_full_d;
  logic [W-1:0]    q_out_d;
  logic [W-1:0]    r_out_d;
  logic            ovf_d;

  // Operand magnitudes at acceptance, one restoring step, and sign fix-up of the final result.
  always_comb begin
    dvd_neg_d   = is_signed & dividend[DW-1];
    dsr_neg_d   = is_signed & divisor[W-1];
    dvd_mag_d   = dvd_neg_d ? -dividend : dividend;
    dsr_mag_d   = dsr_neg_d ? -divisor : divisor;

    shift_rem_d = {rem_q, dvd_q[DW-1]};
    dsr_ext_d   = {2'b00, dsr_mag_q};
    keep_d      = (shift_rem_d >= dsr_ext_d);
    rem_next_d  = keep_d ? (W+1)'(shift_rem_d - dsr_ext_d) : shift_rem_d[W:0];
    dvd_next_d  = {dvd_q[DW-2:0], keep_d};

    q_neg_d     = sgn_q & (dvd_neg_q ^ dsr_neg_q);
    q_full_d    = q_neg_d ? -dvd_q : dvd_q;
    r_out_d     = dvd_neg_q ? -rem_q[W-1:0] : rem_q[W-1:0];

    if (sgn_q) begin
      ovf_d = q_neg_d ? (dvd_q > HALF_RANGE) : (dvd_q >= HALF_RANGE);
    end else begin
      ovf_d = |dvd_q[DW-1:W];
    end

`ifdef DIVIDER_SAT_EN
    if (ovf_d) begin
      if (sgn_q) begin
        q_out_d = q_neg_d ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end else begin
        q_out_d = '1;
      end
    end else begin
      q_out_d = q_full_d[W-1:0];
    end
`else
    q_out_d = q_full_d[W-1:0];
`endif
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      dvd_q       <= '0;
      cnt_q       <= '0;
      dsr_mag_q   <= '0;
      dvd_low_q   <= '0;
      sgn_q       <= 1'b0;
      dvd_neg_q   <= 1'b0;
      dsr_neg_q   <= 1'b0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      overflow_q  <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sgn_q     <= is_signed;
            dvd_neg_q <= dvd_neg_d;
            dsr_neg_q <= dsr_neg_d;
            dvd_low_q <= dividend[W-1:0];
            busy_q    <= 1'b1;
            if (divisor == '0) begin
              zero_q  <= 1'b1;
              state_q <= FIX;
            end else begin
              zero_q    <= 1'b0;
              dsr_mag_q <= dsr_mag_d;
              dvd_q     <= dvd_mag_d;
              rem_q     <= '0;
              cnt_q     <= CW'(DW);
              state_q   <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_next_d;
          dvd_q <= dvd_next_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
          if (zero_q) begin
            quotient_q  <= '1;
            remainder_q <= dvd_low_q;
            overflow_q  <= 1'b0;
            dbz_q       <= 1'b1;
          end else begin
            quotient_q  <= q_out_d;
            remainder_q <= r_out_d;
            overflow_q  <= ovf_d;
            dbz_q       <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign overflow    = overflow_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Directed bench for sequential_divider (data_width = 4).
module tb_sequential_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       is_signed;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       overflow;
  logic       div_by_zero;

  int compareCount  = 0;
  int mismatchCount = 0;

  sequential_divider #(.data_width(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Counts one comparison and reports it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Compares the four result outputs against hand-computed values.
  task automatic expectResult(input string tag, input logic [3:0] q, input logic [3:0] r,
                              input logic ov, input logic dz);
    checkOutput({tag, ".quotient"}, 32'(quotient), 32'(q));
    checkOutput({tag, ".remainder"}, 32'(remainder), 32'(r));
    checkOutput({tag, ".overflow"}, 32'(overflow), 32'(ov));
    checkOutput({tag, ".divByZero"}, 32'(div_by_zero), 32'(dz));
  endtask

  // Launches one division from the current negedge and waits for done.
  // glitchAt >= 0 re-asserts start with other operands in that busy cycle.
  task automatic applyStimulus(input string tag, input logic sgn, input logic [7:0] dd,
                               input logic [3:0] ds, input int expLat, input int glitchAt);
    int   cycles;
    logic busyOk;
    start     = 1'b1;
    is_signed = sgn;
    dividend  = dd;
    divisor   = ds;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    is_signed = ~sgn;
    dividend  = ~dd;
    divisor   = ~ds;
    cycles    = 0;
    busyOk    = 1'b1;
    while (!done && cycles < 40) begin
      if (busy !== 1'b1) busyOk = 1'b0;
      if (cycles == glitchAt) begin
        start     = 1'b1;
        is_signed = 1'b1;
        dividend  = 8'hC8;
        divisor   = 4'h3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    checkOutput({tag, ".done"}, 32'(done), 32'd1);
    checkOutput({tag, ".latency"}, 32'(cycles), 32'(expLat));
    checkOutput({tag, ".busyHeld"}, 32'(busyOk), 32'd1);
    checkOutput({tag, ".busyDrop"}, 32'(busy), 32'd0);
  endtask

  // Main directed sequence; operations run back to back, each started in the previous done cycle.
  initial begin
    logic sawDone;
    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.done", 32'(done), 32'd0);
    expectResult("reset", 4'h0, 4'h0, 1'b0, 1'b0);

    applyStimulus("u15div5", 1'b0, 8'd15, 4'd5, 9, -1);
    expectResult("u15div5", 4'd3, 4'd0, 1'b0, 1'b0);

    applyStimulus("sM21div3", 1'b1, 8'hEB, 4'b0011, 9, -1);
    expectResult("sM21div3", 4'b1001, 4'd0, 1'b0, 1'b0);

    applyStimulus("s8divM1", 1'b1, 8'h08, 4'b1111, 9, -1);
    expectResult("s8divM1", 4'b1000, 4'd0, 1'b0, 1'b0);

    applyStimulus("u200div3", 1'b0, 8'd200, 4'd3, 9, -1);
`ifdef DIVIDER_SAT_EN
    expectResult("u200div3", 4'hF, 4'd2, 1'b1, 1'b0);
`else
    expectResult("u200div3", 4'd2, 4'd2, 1'b1, 1'b0);
`endif

    applyStimulus("sM7div2", 1'b1, 8'hF9, 4'd2, 9, -1);
    expectResult("sM7div2", 4'b1101, 4'b1111, 1'b0, 1'b0);

    applyStimulus("divZero", 1'b0, 8'h5A, 4'd0, 1, -1);
    expectResult("divZero", 4'hF, 4'hA, 1'b0, 1'b1);

    applyStimulus("sMinDiv1", 1'b1, 8'h80, 4'd1, 9, -1);
`ifdef DIVIDER_SAT_EN
    expectResult("sMinDiv1", 4'h8, 4'd0, 1'b1, 1'b0);
`else
    expectResult("sMinDiv1", 4'h0, 4'd0, 1'b1, 1'b0);
`endif

    applyStimulus("s100div3", 1'b1, 8'h64, 4'd3, 9, -1);
`ifdef DIVIDER_SAT_EN
    expectResult("s100div3", 4'h7, 4'd1, 1'b1, 1'b0);
`else
    expectResult("s100div3", 4'h1, 4'd1, 1'b1, 1'b0);
`endif

    applyStimulus("s7divM2", 1'b1, 8'h07, 4'hE, 9, -1);
    expectResult("s7divM2", 4'b1101, 4'd1, 1'b0, 1'b0);

    applyStimulus("glitch", 1'b0, 8'd15, 4'd5, 9, 2);
    expectResult("glitch", 4'd3, 4'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("glitch.donePulse", 32'(done), 32'd0);
    checkOutput("glitch.noRelaunch", 32'(busy), 32'd0);

    start     = 1'b1;
    is_signed = 1'b0;
    dividend  = 8'd200;
    divisor   = 4'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midReset.busy", 32'(busy), 32'd0);
    checkOutput("midReset.done", 32'(done), 32'd0);
    expectResult("midReset", 4'h0, 4'h0, 1'b0, 1'b0);
    rst_n   = 1'b1;
    sawDone = 1'b0;
    repeat (15) begin
      @(posedge clk);
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    checkOutput("midReset.noDone", 32'(sawDone), 32'd0);
    checkOutput("midReset.idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
